// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the RV32 multi-cycle control sequencer.
package cpu_ctrl_pkg;

    // Sequencer states; START is the reset state.
    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    // Next-PC source select.
    typedef enum logic [1:0] {
        PC_SEL_PLUS4 = 2'd0,
        PC_SEL_IMM   = 2'd1,
        PC_SEL_ALU   = 2'd2,
        PC_SEL_RSVD  = 2'd3
    } pc_sel_e;

    // Sticky trap cause.
    typedef enum logic [1:0] {
        CAUSE_NONE         = 2'd0,
        CAUSE_INVALID_OP   = 2'd1,
        CAUSE_IMEM_TIMEOUT = 2'd2,
        CAUSE_DMEM_TIMEOUT = 2'd3
    } trap_cause_e;

    // RV32I major opcodes, shared with the decoder.
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Width of the memory handshake wait counter.
    localparam int unsigned WAIT_W = 8;

    // An instruction needs the MEM phase if it reads or writes data memory.
    function automatic logic needs_mem(input logic mem_we, input logic mem_rd);
        return mem_we | mem_rd;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_mem_wait_timer.sv
// Wait-cycle counter for memory handshakes, shared by FETCH and MEM.
module mem_wait_timer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [WAIT_W-1:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Clear has priority over counting a wait cycle.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WAIT_W'(1);
        end
    end

    // Expiry flags the wait cycle that brings the count up to LIMIT.
    assign expired = en && (count_q == LIMIT - WAIT_W'(1));

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, handshake timeout traps and a retired-instruction counter.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned INSTRET_W      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    input  logic                 imem_ready,
    output logic                 ir_load,
    input  logic                 dec_write_enable,
    input  logic                 dec_mem_write_enable,
    input  logic                 dec_mem_to_reg,
    input  logic                 dec_branch,
    input  logic                 dec_jump,
    input  logic                 dec_jalr,
    input  logic                 dec_invalid_opcode,
    input  logic                 branch_taken,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ready,
    output logic                 rf_we,
    output logic                 pc_load,
    output logic [1:0]           pc_sel,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [INSTRET_W-1:0] instret
);

    state_e                 state_q;
    state_e                 state_d;
    trap_cause_e            trap_cause_q;
    trap_cause_e            trap_cause_d;
    logic [INSTRET_W-1:0]   instret_q;
    logic [INSTRET_W-1:0]   instret_d;
    pc_sel_e                pc_sel_w;

    logic in_fetch;
    logic in_mem;
    logic wait_ready;
    logic wait_clr;
    logic wait_en;
    logic wait_expired;

    // Only one of FETCH/MEM is ever active, so one counter serves both; it
    // is held clear outside the wait states and whenever ready is seen.
    always_comb begin
        in_fetch   = (state_q == ST_FETCH);
        in_mem     = (state_q == ST_MEM);
        wait_ready = in_fetch ? imem_ready : dmem_ready;
        wait_en    = (in_fetch || in_mem) && !wait_ready;
        wait_clr   = !(in_fetch || in_mem) || wait_ready;
    end

    mem_wait_timer #(
        .LIMIT(WAIT_W'(TIMEOUT_CYCLES))
    ) u_wait_timer (
        .clk    (clk),
        .rst    (reset),
        .clr    (wait_clr),
        .en     (wait_en),
        .expired(wait_expired)
    );

    // Next-state, strobes and Mealy pulses; ready beats timeout expiry.
    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        rf_we        = 1'b0;
        pc_load      = 1'b0;
        pc_sel_w     = PC_SEL_PLUS4;

        unique case (state_q)
            ST_START: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    trap_cause_d = CAUSE_IMEM_TIMEOUT;
                    state_d      = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (dec_invalid_opcode) begin
                    trap_cause_d = CAUSE_INVALID_OP;
                    state_d      = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (needs_mem(dec_mem_write_enable, dec_mem_to_reg)) begin
                    state_d = ST_MEM;
                end else if (dec_branch) begin
                    pc_load  = 1'b1;
                    pc_sel_w = branch_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write_enable;
                if (dmem_ready) begin
                    // A store retires here and never reaches WB, so rf_we
                    // stays low even when the load flag is also set.
                    if (dec_mem_write_enable) begin
                        pc_load  = 1'b1;
                        pc_sel_w = PC_SEL_PLUS4;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_expired) begin
                    trap_cause_d = CAUSE_DMEM_TIMEOUT;
                    state_d      = ST_TRAP;
                end
            end
            ST_WB: begin
                rf_we   = dec_write_enable;
                pc_load = 1'b1;
                if (dec_jalr) begin
                    pc_sel_w = PC_SEL_ALU;
                end else if (dec_jump) begin
                    pc_sel_w = PC_SEL_IMM;
                end else begin
                    pc_sel_w = PC_SEL_PLUS4;
                end
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // Retire on the edge that closes the pc_load cycle; wraps naturally.
    always_comb begin
        instret_d = instret_q;
        if (pc_load) begin
            instret_d = instret_q + INSTRET_W'(1);
        end
    end

    // State, trap cause and retired-instruction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_START;
            trap_cause_q <= CAUSE_NONE;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
            instret_q    <= instret_d;
        end
    end

    assign pc_sel     = pc_sel_w;
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = trap_cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: an instruction-level model expands each directed
// instruction into a per-cycle schedule of inputs and expected outputs.
module tb_cpu_ctrl_fsm;

    localparam int IW = 3;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req, imem_ready, ir_load;
    logic          dec_write_enable, dec_mem_write_enable, dec_mem_to_reg;
    logic          dec_branch, dec_jump, dec_jalr, dec_invalid_opcode;
    logic          branch_taken;
    logic          dmem_req, dmem_we, dmem_ready;
    logic          rf_we, pc_load, trap;
    logic [1:0]    pc_sel, trap_cause;
    logic [IW-1:0] instret;

    cpu_ctrl_fsm #(
        .INSTRET_W     (IW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .imem_req            (imem_req),
        .imem_ready          (imem_ready),
        .ir_load             (ir_load),
        .dec_write_enable    (dec_write_enable),
        .dec_mem_write_enable(dec_mem_write_enable),
        .dec_mem_to_reg      (dec_mem_to_reg),
        .dec_branch          (dec_branch),
        .dec_jump            (dec_jump),
        .dec_jalr            (dec_jalr),
        .dec_invalid_opcode  (dec_invalid_opcode),
        .branch_taken        (branch_taken),
        .dmem_req            (dmem_req),
        .dmem_we             (dmem_we),
        .dmem_ready          (dmem_ready),
        .rf_we               (rf_we),
        .pc_load             (pc_load),
        .pc_sel              (pc_sel),
        .trap                (trap),
        .trap_cause          (trap_cause),
        .instret             (instret)
    );

    always #5 clk = ~clk;

    // One clock cycle of stimulus and expectation.
    typedef struct {
        logic        rst;
        logic        imr;
        logic        dmr;
        logic        bt;
        logic [6:0]  dec;   // {we, mwe, m2r, br, jmp, jalr, inv}
        logic [10:0] eo;    // {imreq, irl, dreq, dwe, rfwe, pcl, sel[1:0], trap, cause[1:0]}
        int unsigned ei;    // expected retired count (unwrapped)
        int          lit;   // hand-computed fetch-to-pc_load latency, 0 if none
    } cyc_t;

    cyc_t        sched[$];
    cyc_t        cur;
    logic        have_cur = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    int unsigned m_instret = 0;
    logic [1:0]  m_cause = 2'd0;
    logic [6:0]  g_dec = 7'd0;
    logic        g_bt = 1'b0;

    function automatic logic [10:0] mk(input logic ireq, input logic irl, input logic dreq,
                                       input logic dwe, input logic rfwe, input logic pcl,
                                       input logic [1:0] sel, input logic trp, input logic [1:0] cause);
        return {ireq, irl, dreq, dwe, rfwe, pcl, sel, trp, cause};
    endfunction

    task automatic push(input logic rst, input logic imr, input logic dmr,
                        input logic [10:0] eo, input int lit);
        cyc_t c;
        c.rst = rst;
        c.imr = imr;
        c.dmr = dmr;
        c.bt  = g_bt;
        c.dec = g_dec;
        c.eo  = eo;
        c.ei  = m_instret;
        c.lit = lit;
        sched.push_back(c);
    endtask

    // Reset cycle then the START cycle: everything reads zero.
    task automatic do_reset();
        m_instret = 0;
        m_cause   = 2'd0;
        g_dec     = 7'd0;
        g_bt      = 1'b0;
        push(1'b1, 1'b0, 1'b0, 11'd0, 0);
        push(1'b0, 1'b0, 1'b0, 11'd0, 0);
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++)
            push(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 2'd0, 1'b1, m_cause), 0);
    endtask

    // Expand one instruction: iwait/dwait are low-ready cycles before ready,
    // abort_mem>0 stops after that many MEM cycles, nz drives the other
    // memory's ready high while it must be ignored.
    task automatic add_instr(input logic [6:0] dec, input logic taken, input int iwait,
                             input int dwait, input int abort_mem, input logic nz, input int lit);
        logic we, mwe, m2r, br, jmp, jalr, inv;
        {we, mwe, m2r, br, jmp, jalr, inv} = dec;
        g_dec = dec;
        g_bt  = taken;
        if (iwait >= TO) begin
            for (int i = 0; i < TO; i++)
                push(1'b0, 1'b0, nz, mk(1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0), 0);
            m_cause = 2'd2;
            return;
        end
        for (int i = 0; i < iwait; i++)
            push(1'b0, 1'b0, nz, mk(1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0), 0);
        push(1'b0, 1'b1, nz, mk(1, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0), 0);
        push(1'b0, nz, nz, 11'd0, 0);
        if (inv) begin
            m_cause = 2'd1;
            return;
        end
        if (mwe || m2r) begin
            push(1'b0, nz, nz, 11'd0, 0);
            if (abort_mem > 0) begin
                for (int i = 0; i < abort_mem; i++)
                    push(1'b0, nz, 1'b0, mk(0, 0, 1, mwe, 0, 0, 2'd0, 0, 2'd0), 0);
                return;
            end
            if (dwait >= TO) begin
                for (int i = 0; i < TO; i++)
                    push(1'b0, nz, 1'b0, mk(0, 0, 1, mwe, 0, 0, 2'd0, 0, 2'd0), 0);
                m_cause = 2'd3;
                return;
            end
            for (int i = 0; i < dwait; i++)
                push(1'b0, nz, 1'b0, mk(0, 0, 1, mwe, 0, 0, 2'd0, 0, 2'd0), 0);
            if (mwe) begin
                push(1'b0, nz, 1'b1, mk(0, 0, 1, 1, 0, 1, 2'd0, 0, 2'd0), lit);
                m_instret++;
                return;
            end
            push(1'b0, nz, 1'b1, mk(0, 0, 1, 0, 0, 0, 2'd0, 0, 2'd0), 0);
        end else if (br) begin
            push(1'b0, nz, nz, mk(0, 0, 0, 0, 0, 1, taken ? 2'd1 : 2'd0, 0, 2'd0), lit);
            m_instret++;
            return;
        end else begin
            push(1'b0, nz, nz, 11'd0, 0);
        end
        push(1'b0, nz, nz, mk(0, 0, 0, 0, we, 1, jalr ? 2'd2 : (jmp ? 2'd1 : 2'd0), 0, 2'd0), lit);
        m_instret++;
    endtask

    // Compare process: every scheduled cycle, sampled on the falling edge.
    int            cyc = 0;
    int            fetch_start = 0;
    logic          prev_ireq = 1'b0;
    logic [10:0]   got;
    logic [IW-1:0] exp_i;

    always @(negedge clk) begin
        if (have_cur) begin
            cyc++;
            if (imem_req && !prev_ireq) fetch_start = cyc;
            prev_ireq = imem_req;
            got   = {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_load, pc_sel, trap, trap_cause};
            exp_i = cur.ei[IW-1:0];
            n_cmp++;
            if (got !== cur.eo || instret !== exp_i) begin
                n_bad++;
                $display("FAIL cycle%0d outputs imreq/irl/dreq/dwe/rfwe/pcl/sel/trap/cause: got %b instret %0d, want %b instret %0d",
                         cyc, got, instret, cur.eo, exp_i);
            end
            if (cur.lit != 0) begin
                n_cmp++;
                if (!pc_load || (cyc - fetch_start + 1) != cur.lit) begin
                    n_bad++;
                    $display("FAIL cycle%0d latency: got pc_load=%b after %0d cycles, want pc_load=1 after %0d",
                             cyc, pc_load, cyc - fetch_start + 1, cur.lit);
                end
            end
        end
    end

    initial begin
        reset                = 1'b0;
        imem_ready           = 1'b0;
        dmem_ready           = 1'b0;
        branch_taken         = 1'b0;
        dec_write_enable     = 1'b0;
        dec_mem_write_enable = 1'b0;
        dec_mem_to_reg       = 1'b0;
        dec_branch           = 1'b0;
        dec_jump             = 1'b0;
        dec_jalr             = 1'b0;
        dec_invalid_opcode   = 1'b0;

        //                       we mwe m2r br jmp jalr inv
        do_reset();
        add_instr(7'b1000000, 1'b0, 0, 0, 0, 1'b0, 4);  // R-type add
        add_instr(7'b0001000, 1'b1, 0, 0, 0, 1'b0, 3);  // branch taken
        add_instr(7'b0001000, 1'b0, 0, 0, 0, 1'b1, 3);  // branch not taken
        add_instr(7'b1010000, 1'b0, 0, 3, 0, 1'b0, 8);  // load, 3 wait cycles
        add_instr(7'b0100000, 1'b0, 0, 0, 0, 1'b1, 4);  // store
        add_instr(7'b1110000, 1'b0, 0, 0, 0, 1'b0, 4);  // store+load flags
        add_instr(7'b1000100, 1'b0, 0, 0, 0, 1'b0, 4);  // jal
        add_instr(7'b1000110, 1'b0, 0, 0, 0, 1'b1, 4);  // jalr (+jump flag)
        add_instr(7'b1000000, 1'b0, 3, 0, 0, 1'b1, 7);  // ready on 4th fetch cycle
        add_instr(7'b1010000, 1'b0, 0, 0, 0, 1'b0, 5);  // load zero-wait
        add_instr(7'b0100000, 1'b0, 0, 0, 2, 1'b0, 0);  // store aborted in MEM
        do_reset();
        add_instr(7'b1000000, 1'b0, 0, 0, 0, 1'b0, 4);
        add_instr(7'b1000001, 1'b0, 0, 0, 0, 1'b0, 0);  // invalid opcode
        trap_hold(5);
        do_reset();
        add_instr(7'b1000000, 1'b0, 4, 0, 0, 1'b0, 0);  // imem timeout
        trap_hold(3);
        do_reset();
        add_instr(7'b1010000, 1'b0, 0, 4, 0, 1'b1, 0);  // dmem timeout
        trap_hold(3);
        do_reset();
        add_instr(7'b1000000, 1'b0, 0, 0, 0, 1'b0, 4);

        #1 reset = 1'b1;
        while (sched.size() > 0) begin
            @(posedge clk);
            #1;
            cur = sched.pop_front();
            reset        = cur.rst;
            imem_ready   = cur.imr;
            dmem_ready   = cur.dmr;
            branch_taken = cur.bt;
            {dec_write_enable, dec_mem_write_enable, dec_mem_to_reg, dec_branch,
             dec_jump, dec_jalr, dec_invalid_opcode} = cur.dec;
            have_cur = 1'b1;
        end
        @(posedge clk);
        #1 have_cur = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
